// File: rtl/reset_vote_pkg.sv
// -----------------------------------------------------------------------------
// reset_vote_pkg
// Shared types and helpers for the voted reset release block.
//   state_t          : release FSM states (HOLD, STRETCH, RUN)
//   REPLICA_*        : encoding of the minority replica reported on bad_replica
//   majority3()      : 2-of-3 vote of the synchronised replicas
//   minorityReplica(): identifies the single replica that differs from the rest
// -----------------------------------------------------------------------------
package reset_vote_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam logic [1:0] REPLICA_NONE = 2'd0;
    localparam logic [1:0] REPLICA_A    = 2'd1;
    localparam logic [1:0] REPLICA_B    = 2'd2;
    localparam logic [1:0] REPLICA_C    = 2'd3;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // With three binary inputs that are not all equal, exactly one of them
    // is the odd one out; NONE is only returned when all three agree.
    function automatic logic [1:0] minorityReplica(input logic a, input logic b, input logic c);
        logic [1:0] id;
        if ((a != b) && (a != c)) begin
            id = REPLICA_A;
        end else if ((b != a) && (b != c)) begin
            id = REPLICA_B;
        end else if ((c != a) && (c != b)) begin
            id = REPLICA_C;
        end else begin
            id = REPLICA_NONE;
        end
        return id;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Multi-flop synchroniser for one asynchronous reset-request replica.
// All flops reset to 1 so the replica reads as "reset requested" until the
// real input has propagated through the chain.
// Ports:
//   clk  : destination clock
//   rst  : asynchronous active-high reset (chain forced to all ones)
//   din  : asynchronous input
//   dout : synchronised output (last stage of the chain)
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chainQ;

    // Shift the input through the chain; async reset preloads ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chainQ <= {STAGES{1'b1}};
        end else begin
            chainQ <= {chainQ[STAGES-2:0], din};
        end
    end

    assign dout = chainQ[STAGES-1];

endmodule

// File: rtl/reset_vote_release.sv
// -----------------------------------------------------------------------------
// reset_vote_release
// Consumer side of the triplicated reset tree. Each replica request is
// synchronised, the three are majority-voted, and the local reset is only
// released after the voted request has stayed low for RELEASE_CYCLES cycles.
// Persistent disagreement between replicas is reported as mismatch events.
// Ports:
//   clk          : block clock
//   rst          : asynchronous active-high reset
//   rst_req_a/b/c: replicated reset requests, active-high, async to clk
//   err_clr      : synchronous clear of mismatch status
//   rst_out      : voted, stretched local reset (registered, active-high)
//   mismatch     : sticky mismatch-event flag
//   bad_replica  : minority replica of the latest event (0 none,1 A,2 B,3 C)
//   mismatch_cnt : saturating count of mismatch events
// -----------------------------------------------------------------------------
module reset_vote_release
    import reset_vote_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int RELEASE_CYCLES = 16,
    parameter int MISMATCH_LIMIT = 4,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_req_a,
    input  logic             rst_req_b,
    input  logic             rst_req_c,
    input  logic             err_clr,
    output logic             rst_out,
    output logic             mismatch,
    output logic [1:0]       bad_replica,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam int STRETCH_W = $clog2(RELEASE_CYCLES) + 1;
    localparam int RUN_W     = $clog2(MISMATCH_LIMIT + 1);

    localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'(RELEASE_CYCLES - 1);
    localparam logic [RUN_W-1:0]     RUN_LIMIT    = RUN_W'(MISMATCH_LIMIT);
    localparam logic [RUN_W-1:0]     RUN_PRE      = RUN_W'(MISMATCH_LIMIT - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX      = {CNT_W{1'b1}};

    logic syncA;
    logic syncB;
    logic syncC;
    logic vote;
    logic disagree;
    logic mismatchEvent;

    state_t               stateQ;
    state_t               stateNxt;
    logic [STRETCH_W-1:0] stretchCntQ;
    logic [STRETCH_W-1:0] stretchCntNxt;
    logic                 rstOutQ;

    logic [RUN_W-1:0]     runCntQ;
    logic [RUN_W-1:0]     runCntNxt;
    logic                 mismatchQ;
    logic                 mismatchNxt;
    logic [1:0]           badReplicaQ;
    logic [1:0]           badReplicaNxt;
    logic [CNT_W-1:0]     mismatchCntQ;
    logic [CNT_W-1:0]     mismatchCntNxt;

    sync_chain #(.STAGES(SYNC_STAGES)) uSyncA (
        .clk  (clk),
        .rst  (rst),
        .din  (rst_req_a),
        .dout (syncA)
    );

    sync_chain #(.STAGES(SYNC_STAGES)) uSyncB (
        .clk  (clk),
        .rst  (rst),
        .din  (rst_req_b),
        .dout (syncB)
    );

    sync_chain #(.STAGES(SYNC_STAGES)) uSyncC (
        .clk  (clk),
        .rst  (rst),
        .din  (rst_req_c),
        .dout (syncC)
    );

    assign vote     = majority3(syncA, syncB, syncC);
    assign disagree = !((syncA == syncB) && (syncB == syncC));

    // Release FSM next-state and stretch counter.
    always_comb begin
        stateNxt      = stateQ;
        stretchCntNxt = stretchCntQ;
        case (stateQ)
            HOLD: begin
                if (!vote) begin
                    stateNxt      = STRETCH;
                    stretchCntNxt = {STRETCH_W{1'b0}};
                end else begin
                    stateNxt = HOLD;
                end
            end
            STRETCH: begin
                if (vote) begin
                    stateNxt = HOLD;
                end else if (stretchCntQ == STRETCH_LAST) begin
                    // Counter parks at its terminal value, so it never wraps.
                    stateNxt = RUN;
                end else begin
                    stretchCntNxt = stretchCntQ + STRETCH_W'(1);
                end
            end
            RUN: begin
                if (vote) begin
                    stateNxt = HOLD;
                end else begin
                    stateNxt = RUN;
                end
            end
            default: begin
                stateNxt      = HOLD;
                stretchCntNxt = {STRETCH_W{1'b0}};
            end
        endcase
    end

    // FSM state, stretch counter and registered reset output.
    // rst_out is decoded from the next state so it changes on the same edge
    // as the state and leaves the block straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ      <= HOLD;
            stretchCntQ <= {STRETCH_W{1'b0}};
            rstOutQ     <= 1'b1;
        end else begin
            stateQ      <= stateNxt;
            stretchCntQ <= stretchCntNxt;
            rstOutQ     <= (stateNxt != RUN);
        end
    end

    // Disagreement run length and mismatch status next-state.
    always_comb begin
        runCntNxt      = runCntQ;
        mismatchNxt    = mismatchQ;
        badReplicaNxt  = badReplicaQ;
        mismatchCntNxt = mismatchCntQ;

        if (disagree) begin
            if (runCntQ != RUN_LIMIT) begin
                runCntNxt = runCntQ + RUN_W'(1);
            end else begin
                runCntNxt = runCntQ;
            end
        end else begin
            runCntNxt = {RUN_W{1'b0}};
        end

        // Fires only on the step into the limit, so one run gives one event.
        mismatchEvent = disagree && (runCntQ == RUN_PRE);

        if (mismatchEvent) begin
            // An event on the same cycle as err_clr takes precedence.
            mismatchNxt   = 1'b1;
            badReplicaNxt = minorityReplica(syncA, syncB, syncC);
            if (err_clr) begin
                mismatchCntNxt = CNT_W'(1);
            end else if (mismatchCntQ != CNT_MAX) begin
                mismatchCntNxt = mismatchCntQ + CNT_W'(1);
            end else begin
                mismatchCntNxt = mismatchCntQ;
            end
        end else if (err_clr) begin
            mismatchNxt    = 1'b0;
            badReplicaNxt  = REPLICA_NONE;
            mismatchCntNxt = {CNT_W{1'b0}};
        end else begin
            mismatchNxt    = mismatchQ;
            badReplicaNxt  = badReplicaQ;
            mismatchCntNxt = mismatchCntQ;
        end
    end

    // Mismatch tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            runCntQ      <= {RUN_W{1'b0}};
            mismatchQ    <= 1'b0;
            badReplicaQ  <= REPLICA_NONE;
            mismatchCntQ <= {CNT_W{1'b0}};
        end else begin
            runCntQ      <= runCntNxt;
            mismatchQ    <= mismatchNxt;
            badReplicaQ  <= badReplicaNxt;
            mismatchCntQ <= mismatchCntNxt;
        end
    end

    assign rst_out      = rstOutQ;
    assign mismatch     = mismatchQ;
    assign bad_replica  = badReplicaQ;
    assign mismatch_cnt = mismatchCntQ;

endmodule
